// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int MAX_WAIT_DEF  = 4;
  localparam int MAX_BURST_DEF = 8;
  localparam int STAT_W        = 16;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_PER  = 2'd2
  } rd_owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data RAM.
//
// Handshake: a requester raises req with addr/we/wdata and holds them
// stable until gnt is seen high in the same cycle; that cycle is the
// access. A granted read returns rvalid/rdata exactly one cycle later;
// writes return nothing. slave = arbiter side, master = requester/RAM side.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              per_req;
  logic              per_we;
  logic              per_lock;
  logic [ADDR_W-1:0] per_addr;
  logic [DATA_W-1:0] per_wdata;
  logic              per_gnt;
  logic              per_rvalid;
  logic [DATA_W-1:0] per_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [STAT_W-1:0] stat_cpu_stalls;
  logic [STAT_W-1:0] stat_per_grants;
  arb_state_t        state_dbg;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  per_req, per_we, per_lock, per_addr, per_wdata,
    output per_gnt, per_rvalid, per_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output stat_cpu_stalls, stat_per_grants, state_dbg
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output per_req, per_we, per_lock, per_addr, per_wdata,
    input  per_gnt, per_rvalid, per_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  stat_cpu_stalls, stat_per_grants, state_dbg
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data RAM arbiter (CPU load/store vs peripheral master).
// CPU has priority; the peripheral takes over after MAX_WAIT denied cycles
// and may lock the RAM for up to MAX_BURST consecutive grants, after which
// the CPU is guaranteed the next cycle.
// Optional statistics counters: define DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_WAIT  = MAX_WAIT_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  arb_state_t        state;
  rd_owner_t         rd_owner;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic              force_cpu;
  logic              cpu_win;
  logic              per_win;
  logic              mux_we;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;

  // Grant decision: burst holder first, then CPU priority unless the
  // peripheral has waited long enough (and no post-burst CPU turn is owed).
  always_comb begin
    cpu_win = 1'b0;
    per_win = 1'b0;
    if (!rst) begin
      if (state == BURST && bus.per_req && bus.per_lock) begin
        per_win = 1'b1;
      end else if (bus.cpu_req && bus.per_req) begin
        if (wait_cnt == WAIT_MAX && !force_cpu) per_win = 1'b1;
        else                                    cpu_win = 1'b1;
      end else begin
        cpu_win = bus.cpu_req;
        per_win = bus.per_req;
      end
    end
  end

  // RAM port mux: driven only from the granted requester, zero when idle.
  always_comb begin
    mux_we    = 1'b0;
    mux_addr  = '0;
    mux_wdata = '0;
    if (cpu_win) begin
      mux_we    = bus.cpu_we;
      mux_addr  = bus.cpu_addr;
      mux_wdata = bus.cpu_wdata;
    end else if (per_win) begin
      mux_we    = bus.per_we;
      mux_addr  = bus.per_addr;
      mux_wdata = bus.per_wdata;
    end
  end

  // Arbitration state, wait/burst counters and read-return owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      rd_owner  <= OWN_NONE;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      force_cpu <= 1'b0;
    end else begin
      force_cpu <= 1'b0;

      if (cpu_win && !bus.cpu_we)      rd_owner <= OWN_CPU;
      else if (per_win && !bus.per_we) rd_owner <= OWN_PER;
      else                             rd_owner <= OWN_NONE;

      if (!bus.per_req || per_win)  wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;

      case (state)
        ARB: begin
          if (per_win && bus.per_lock) begin
            if (MAX_BURST == 1) begin
              force_cpu <= 1'b1;
              burst_cnt <= '0;
            end else begin
              state     <= BURST;
              burst_cnt <= BURST_W'(1);
            end
          end
        end
        BURST: begin
          if (bus.per_req && bus.per_lock) begin
            if ((burst_cnt + 1'b1) == BURST_MAX) begin
              state     <= ARB;
              burst_cnt <= '0;
              force_cpu <= 1'b1;
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end else begin
            state     <= ARB;
            burst_cnt <= '0;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign bus.cpu_gnt    = cpu_win;
  assign bus.per_gnt    = per_win;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_win & ~rst;
  assign bus.mem_we     = mux_we;
  assign bus.mem_addr   = mux_addr;
  assign bus.mem_wdata  = mux_wdata;
  assign bus.cpu_rvalid = (rd_owner == OWN_CPU);
  assign bus.per_rvalid = (rd_owner == OWN_PER);
  assign bus.cpu_rdata  = (rd_owner == OWN_CPU) ? bus.mem_rdata : '0;
  assign bus.per_rdata  = (rd_owner == OWN_PER) ? bus.mem_rdata : '0;
  assign bus.state_dbg  = state;

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] stall_cnt;
  logic [STAT_W-1:0] pgnt_cnt;

  // Saturating event counters for stall cycles and peripheral grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      pgnt_cnt  <= '0;
    end else begin
      if (bus.cpu_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (per_win && pgnt_cnt != '1)        pgnt_cnt  <= pgnt_cnt + 1'b1;
    end
  end

  assign bus.stat_cpu_stalls = stall_cnt;
  assign bus.stat_per_grants = pgnt_cnt;
`else
  assign bus.stat_cpu_stalls = '0;
  assign bus.stat_per_grants = '0;
`endif

endmodule
